// File: rtl/mdu_pkg.sv
// Shared types and constants for the multiply/divide issue logic.
`timescale 1ns/1ps

package mdu_pkg;

   // Function code presented to the HI/LO multiply/divide unit
   localparam int W_FUNC = 2;
   localparam logic [W_FUNC-1:0] FUNC_NOP = 2'd0;
   localparam logic [W_FUNC-1:0] FUNC_MUL = 2'd1;
   localparam logic [W_FUNC-1:0] FUNC_DIV = 2'd2;

   // Operation requested by the ID/EX register
   typedef enum logic [2:0] {
      OP_MULT  = 3'd0,
      OP_MULTU = 3'd1,
      OP_DIV   = 3'd2,
      OP_DIVU  = 3'd3,
      OP_MTHI  = 3'd4,
      OP_MTLO  = 3'd5,
      OP_MFHI  = 3'd6,
      OP_MFLO  = 3'd7
   } mdu_op_t;

   // Issue sequencer states
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_BUSY   = 2'd1,
      ST_RETIRE = 2'd2
   } state_t;

   // Unit function for an arithmetic op (only meaningful for MULT/MULTU/DIV/DIVU)
   function automatic logic [W_FUNC-1:0] op_func(input mdu_op_t op);
      return ((op == OP_MULT) || (op == OP_MULTU)) ? FUNC_MUL : FUNC_DIV;
   endfunction

   // Signed flavour of an arithmetic op
   function automatic logic op_signed(input mdu_op_t op);
      return (op == OP_MULT) || (op == OP_DIV);
   endfunction

endpackage

// File: rtl/mdu_watchdog.sv
// Watchdog for the BUSY state: counts cycles the unit keeps stalling and
// raises a one-cycle expiry plus a sticky error flag.
`timescale 1ns/1ps

module mdu_watchdog #(
   parameter int TIMEOUT_CYC = 64,
   parameter int CNT_W       = 7     // 2**CNT_W must exceed TIMEOUT_CYC
) (
   input  logic clk,
   input  logic rst,          // synchronous, active-low
   input  logic clear,        // entering BUSY: restart the count
   input  logic count_en,     // BUSY and unit still stalling
   input  logic kill,         // a flush is aborting the op anyway
   output logic expired,      // this is the last tolerated stalled cycle
   output logic err_timeout
);

   logic [CNT_W-1:0] cnt_reg;
   logic             err_reg;

   // The count holds n-1 during the n-th stalled cycle, so expiry lands on cycle TIMEOUT_CYC
   assign expired     = count_en && (cnt_reg == CNT_W'(TIMEOUT_CYC - 1));
   assign err_timeout = err_reg;

   // Stalled-cycle counter and sticky error flag; only reset clears the flag
   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_reg <= '0;
         err_reg <= 1'b0;
      end else begin
         if (clear) begin
            cnt_reg <= '0;
         end else if (count_en) begin
            cnt_reg <= cnt_reg + 1'b1;
         end
         if (expired && !kill) begin
            err_reg <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/muldiv_issue.sv
// EX-stage initiator for the multi-cycle HI/LO multiply/divide unit.
// Holds one arithmetic op on the unit interface until it retires, sequences
// HI/LO moves, forwards flushes and aborts a hung unit via the watchdog.
`timescale 1ns/1ps

module muldiv_issue
   import mdu_pkg::*;
#(
   parameter int TIMEOUT_CYC = 64,
   parameter int CNT_W       = 7
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2:0]        in_op,
   input  logic [31:0]       in_src_a,
   input  logic [31:0]       in_src_b,
   input  logic              pipe_flush,
   input  logic              pipe_stall_in,
   output logic              stall_req,
   output logic              out_valid,
   output logic [31:0]       out_data,
   output logic              err_timeout,
   output logic [W_FUNC-1:0] u_func,
   output logic              u_sign,
   output logic [31:0]       u_src_a,
   output logic [31:0]       u_src_b,
   input  logic              u_stall,
   output logic              u_reg_stall,
   output logic              u_flush,
   input  logic [31:0]       u_hi,
   input  logic [31:0]       u_lo,
   output logic              u_hi_write,
   output logic [31:0]       u_hi_wdata,
   output logic              u_lo_write,
   output logic [31:0]       u_lo_wdata
);

   state_t            state_reg,     state_next;
   logic [W_FUNC-1:0] u_func_reg,    u_func_next;
   logic              u_sign_reg,    u_sign_next;
   logic [31:0]       src_a_reg,     src_a_next;
   logic [31:0]       src_b_reg,     src_b_next;
   logic              out_valid_reg, out_valid_next;
   logic [31:0]       out_data_reg,  out_data_next;
   logic              u_flush_reg,   u_flush_next;
   logic              hi_write_reg,  hi_write_next;
   logic              lo_write_reg,  lo_write_next;
   logic [31:0]       wdata_reg,     wdata_next;

   mdu_op_t op;
   logic    accept;
   logic    wd_clear;
   logic    wd_expired;

   assign op     = mdu_op_t'(in_op);
   assign accept = (state_reg == ST_IDLE) && in_valid && !pipe_flush;

   // Handshake/hazard outputs; a unit that finished but is held by a downstream stall no longer stalls us
   assign in_ready    = rst && (state_reg == ST_IDLE);
   assign stall_req   = (state_reg == ST_BUSY) && (u_stall || !pipe_stall_in);
   assign u_reg_stall = pipe_stall_in;

   assign u_func     = u_func_reg;
   assign u_sign     = u_sign_reg;
   assign u_src_a    = src_a_reg;
   assign u_src_b    = src_b_reg;
   assign u_flush    = u_flush_reg;
   assign out_valid  = out_valid_reg;
   assign out_data   = out_data_reg;
   assign u_hi_write = hi_write_reg;
   assign u_lo_write = lo_write_reg;
   assign u_hi_wdata = wdata_reg;
   assign u_lo_wdata = wdata_reg;

   mdu_watchdog #(
      .TIMEOUT_CYC (TIMEOUT_CYC),
      .CNT_W       (CNT_W)
   ) u_watchdog (
      .clk         (clk),
      .rst         (rst),
      .clear       (wd_clear),
      .count_en    ((state_reg == ST_BUSY) && u_stall),
      .kill        (pipe_flush),
      .expired     (wd_expired),
      .err_timeout (err_timeout)
   );

   // Next-state and next-output decode; strobes default low so they last one cycle
   always_comb begin
      state_next     = state_reg;
      u_func_next    = u_func_reg;
      u_sign_next    = u_sign_reg;
      src_a_next     = src_a_reg;
      src_b_next     = src_b_reg;
      out_valid_next = 1'b0;
      out_data_next  = out_data_reg;
      u_flush_next   = 1'b0;
      hi_write_next  = 1'b0;
      lo_write_next  = 1'b0;
      wdata_next     = wdata_reg;
      wd_clear       = 1'b0;

      case (state_reg)
         ST_IDLE: begin
            if (accept) begin
               case (op)
                  OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                     src_a_next  = in_src_a;
                     src_b_next  = in_src_b;
                     u_sign_next = op_signed(op);
                     u_func_next = op_func(op);
                     wd_clear    = 1'b1;
                     state_next  = ST_BUSY;
                  end
                  OP_MTHI: begin
                     hi_write_next = 1'b1;
                     wdata_next    = in_src_a;
                  end
                  OP_MTLO: begin
                     lo_write_next = 1'b1;
                     wdata_next    = in_src_a;
                  end
                  OP_MFHI: begin
                     // A move-to still in flight has not reached the unit yet; forward it
                     out_valid_next = 1'b1;
                     out_data_next  = hi_write_reg ? wdata_reg : u_hi;
                  end
                  OP_MFLO: begin
                     out_valid_next = 1'b1;
                     out_data_next  = lo_write_reg ? wdata_reg : u_lo;
                  end
                  default: ;
               endcase
            end
         end

         ST_BUSY: begin
            if (pipe_flush || wd_expired) begin
               u_flush_next = 1'b1;
               u_func_next  = FUNC_NOP;
               state_next   = ST_IDLE;
            end else if (!u_stall && !pipe_stall_in) begin
               u_func_next = FUNC_NOP;
               state_next  = ST_RETIRE;
            end
         end

         ST_RETIRE: begin
            // One NOP cycle so the unit drops back to idle before anything new is launched
            u_flush_next = pipe_flush;
            state_next   = ST_IDLE;
         end

         default: begin
            u_func_next = FUNC_NOP;
            state_next  = ST_IDLE;
         end
      endcase
   end

   // State and registered outputs; everything returns to its idle value on reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg     <= ST_IDLE;
         u_func_reg    <= FUNC_NOP;
         u_sign_reg    <= 1'b0;
         src_a_reg     <= '0;
         src_b_reg     <= '0;
         out_valid_reg <= 1'b0;
         out_data_reg  <= '0;
         u_flush_reg   <= 1'b0;
         hi_write_reg  <= 1'b0;
         lo_write_reg  <= 1'b0;
         wdata_reg     <= '0;
      end else begin
         state_reg     <= state_next;
         u_func_reg    <= u_func_next;
         u_sign_reg    <= u_sign_next;
         src_a_reg     <= src_a_next;
         src_b_reg     <= src_b_next;
         out_valid_reg <= out_valid_next;
         out_data_reg  <= out_data_next;
         u_flush_reg   <= u_flush_next;
         hi_write_reg  <= hi_write_next;
         lo_write_reg  <= lo_write_next;
         wdata_reg     <= wdata_next;
      end
   end

endmodule

// File: tb/tb_muldiv_issue.sv
// Self-checking bench for muldiv_issue with a behavioural multiply/divide unit.
`timescale 1ns/1ps

module tb_muldiv_issue;
   import mdu_pkg::*;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic [2:0]        in_op;
   logic [31:0]       in_src_a;
   logic [31:0]       in_src_b;
   logic              pipe_flush;
   logic              pipe_stall_in;
   logic              stall_req;
   logic              out_valid;
   logic [31:0]       out_data;
   logic              err_timeout;
   logic [W_FUNC-1:0] u_func;
   logic              u_sign;
   logic [31:0]       u_src_a;
   logic [31:0]       u_src_b;
   logic              u_stall;
   logic              u_reg_stall;
   logic              u_flush;
   logic [31:0]       u_hi;
   logic [31:0]       u_lo;
   logic              u_hi_write;
   logic [31:0]       u_hi_wdata;
   logic              u_lo_write;
   logic [31:0]       u_lo_wdata;

   int checks = 0;
   int errors = 0;

   // Reference HI/LO as the architecture should see them
   logic [31:0] m_hi = '0;
   logic [31:0] m_lo = '0;

   always #5 clk = ~clk;

   muldiv_issue #(.TIMEOUT_CYC(64), .CNT_W(7)) dut (
      .clk           (clk),
      .rst           (rst),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_op         (in_op),
      .in_src_a      (in_src_a),
      .in_src_b      (in_src_b),
      .pipe_flush    (pipe_flush),
      .pipe_stall_in (pipe_stall_in),
      .stall_req     (stall_req),
      .out_valid     (out_valid),
      .out_data      (out_data),
      .err_timeout   (err_timeout),
      .u_func        (u_func),
      .u_sign        (u_sign),
      .u_src_a       (u_src_a),
      .u_src_b       (u_src_b),
      .u_stall       (u_stall),
      .u_reg_stall   (u_reg_stall),
      .u_flush       (u_flush),
      .u_hi          (u_hi),
      .u_lo          (u_lo),
      .u_hi_write    (u_hi_write),
      .u_hi_wdata    (u_hi_wdata),
      .u_lo_write    (u_lo_write),
      .u_lo_wdata    (u_lo_wdata)
   );

   // ---------------- behavioural multiply/divide unit ----------------
   logic        hang = 1'b0;    // stuck unit: stall forever, never finish
   int          launches = 0;
   int          un_state = 0;   // 0 idle, 1 computing, 2 done and waiting for NOP
   int          un_cnt = 0;
   logic [63:0] un_pend = '0;
   logic [31:0] un_hi = '0;
   logic [31:0] un_lo = '0;

   function automatic logic [63:0] unit_calc(input logic [W_FUNC-1:0] f, input logic s,
                                             input logic [31:0] a, input logic [31:0] b);
      logic [63:0] r;
      if (f == FUNC_MUL) begin
         if (s) r = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
         else   r = {32'b0, a} * {32'b0, b};
      end else begin
         if (s) r = {32'($signed(a) % $signed(b)), 32'($signed(a) / $signed(b))};
         else   r = {a % b, a / b};
      end
      return r;
   endfunction

   assign u_hi    = un_hi;
   assign u_lo    = un_lo;
   assign u_stall = hang || (un_state == 1) || ((un_state == 0) && (u_func != FUNC_NOP));

   always @(posedge clk) begin
      if (!rst) begin
         un_state <= 0;
         un_cnt   <= 0;
         un_hi    <= '0;
         un_lo    <= '0;
      end else begin
         if (u_hi_write) un_hi <= u_hi_wdata;
         if (u_lo_write) un_lo <= u_lo_wdata;
         if (u_flush) begin
            un_state <= 0;
         end else if (!hang) begin
            case (un_state)
               0: if (u_func != FUNC_NOP) begin
                     un_pend  <= unit_calc(u_func, u_sign, u_src_a, u_src_b);
                     un_cnt   <= (u_func == FUNC_MUL) ? 1 + int'(u_src_b[2:0]) : 33;
                     un_state <= 1;
                     launches <= launches + 1;
                  end
               1: if (un_cnt == 0) begin
                     un_hi    <= un_pend[63:32];
                     un_lo    <= un_pend[31:0];
                     un_state <= 2;
                  end else begin
                     un_cnt <= un_cnt - 1;
                  end
               default: if (u_func == FUNC_NOP) un_state <= 0;
            endcase
         end
      end
   end

   // ---------------- checking helpers ----------------
   task automatic check1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Present one request and return #1 after the edge that accepts it
   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      int guard = 0;
      in_op    = op;
      in_src_a = a;
      in_src_b = b;
      in_valid = 1'b1;
      #1;
      while (!in_ready && guard < 300) begin
         @(posedge clk); #1;
         guard++;
      end
      if (!in_ready) check1("issue_ready_timeout", in_ready, 1'b1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   // Run one op to completion, check the interface and keep the reference HI/LO up to date
   task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] mf_data);
      logic [W_FUNC-1:0] exp_func;
      logic              exp_sign;
      logic              stable;
      int                guard;
      int                n_ret;
      int                sa, sb;
      longint            p;
      mf_data = '0;
      $display("op=%0d a=%h b=%h hi=%h lo=%h", op, a, b, m_hi, m_lo);
      issue(op, a, b);
      if (op == OP_MTHI || op == OP_MTLO) begin
         check1("mt_hi_write", u_hi_write, op == OP_MTHI);
         check1("mt_lo_write", u_lo_write, op == OP_MTLO);
         check32("mt_wdata", (op == OP_MTHI) ? u_hi_wdata : u_lo_wdata, a);
         if (op == OP_MTHI) m_hi = a; else m_lo = a;
         @(posedge clk); #1;
         check1("mt_single_pulse", u_hi_write | u_lo_write, 1'b0);
      end else if (op == OP_MFHI || op == OP_MFLO) begin
         check1("mf_out_valid", out_valid, 1'b1);
         mf_data = out_data;
         check32((op == OP_MFHI) ? "mfhi_data" : "mflo_data", out_data,
                 (op == OP_MFHI) ? m_hi : m_lo);
         @(posedge clk); #1;
         check1("mf_single_pulse", out_valid, 1'b0);
      end else begin
         exp_func = (op == OP_MULT || op == OP_MULTU) ? FUNC_MUL : FUNC_DIV;
         exp_sign = (op == OP_MULT || op == OP_DIV);
         check32("launch_func", 32'(u_func), 32'(exp_func));
         check1("launch_sign", u_sign, exp_sign);
         check32("launch_src_a", u_src_a, a);
         check32("launch_src_b", u_src_b, b);
         check1("launch_stall_req", stall_req, 1'b1);
         stable = 1'b1;
         guard  = 0;
         n_ret  = 0;
         while (!in_ready && guard < 300) begin
            if (u_func != FUNC_NOP) begin
               if (u_func !== exp_func || u_sign !== exp_sign ||
                   u_src_a !== a || u_src_b !== b || stall_req !== 1'b1) stable = 1'b0;
            end else begin
               n_ret++;
               if (stall_req !== 1'b0) stable = 1'b0;
            end
            @(posedge clk); #1;
            guard++;
         end
         check1("busy_stable", stable, 1'b1);
         check1("op_retired", in_ready, 1'b1);
         check32("retire_cycles", 32'(n_ret), 32'd1);
         sa = a;
         sb = b;
         case (op)
            OP_MULT:  begin p = longint'(sa) * longint'(sb); m_hi = p[63:32]; m_lo = p[31:0]; end
            OP_MULTU: begin p = longint'(a) * longint'(b);   m_hi = p[63:32]; m_lo = p[31:0]; end
            OP_DIV:   begin m_lo = sa / sb; m_hi = sa % sb; end
            default:  begin m_lo = a / b;   m_hi = a % b;   end
         endcase
      end
   endtask

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp_hi;
      logic [31:0] exp_lo;
   } vec_t;

   // Global bound so a wedged design still ends with a report
   initial begin
      #600000;
      $display("FAIL global_timeout: got still running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t        vecs[9];
      logic [31:0] d;
      logic [2:0]  rop;
      logic [31:0] ra, rb;
      int          n0, held, guard, cyc;
      logic        ok;

      vecs[0] = '{OP_MULT,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1};
      vecs[1] = '{OP_DIVU,  32'd100,      32'd7,        32'h00000002, 32'h0000000E};
      vecs[2] = '{OP_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
      vecs[3] = '{OP_MULTU, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE};
      vecs[4] = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
      vecs[5] = '{OP_MTHI,  32'h00001234, 32'd0,        32'h00001234, 32'hFFFFFFFD};
      vecs[6] = '{OP_MTLO,  32'h00005678, 32'd0,        32'h00001234, 32'h00005678};
      vecs[7] = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
      vecs[8] = '{OP_DIVU,  32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF};

      rst = 1'b0; in_valid = 1'b0; in_op = '0; in_src_a = '0; in_src_b = '0;
      pipe_flush = 1'b0; pipe_stall_in = 1'b0;
      repeat (3) @(posedge clk);
      #1;

      // Reset values
      check1("rst_in_ready", in_ready, 1'b0);
      check1("rst_stall_req", stall_req, 1'b0);
      check1("rst_out_valid", out_valid, 1'b0);
      check1("rst_u_flush", u_flush, 1'b0);
      check1("rst_hi_write", u_hi_write, 1'b0);
      check1("rst_lo_write", u_lo_write, 1'b0);
      check1("rst_err_timeout", err_timeout, 1'b0);
      check1("rst_u_sign", u_sign, 1'b0);
      check32("rst_out_data", out_data, 32'h0);
      check32("rst_u_src_a", u_src_a, 32'h0);
      check32("rst_u_src_b", u_src_b, 32'h0);
      check32("rst_u_func", 32'(u_func), 32'(FUNC_NOP));
      rst = 1'b1;
      #1;
      check1("idle_in_ready", in_ready, 1'b1);

      // Table of directed vectors, each followed by MFHI/MFLO read-back
      for (int i = 0; i < 9; i++) begin
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, d);
         run_op(OP_MFHI, 32'h0, 32'h0, d);
         check32($sformatf("vec%0d_hi", i), d, vecs[i].exp_hi);
         run_op(OP_MFLO, 32'h0, 32'h0, d);
         check32($sformatf("vec%0d_lo", i), d, vecs[i].exp_lo);
      end

      // Downstream stall held for 3 cycles after the unit finishes
      $display("seq: pipe_stall_in hold");
      n0 = launches; held = 0; guard = 0; ok = 1'b1;
      issue(OP_DIVU, 32'd50, 32'd6);
      pipe_stall_in = 1'b1;
      while (held < 3 && guard < 300) begin
         if (!u_stall) begin
            held++;
            if (stall_req !== 1'b0 || u_func !== FUNC_DIV || u_reg_stall !== 1'b1) ok = 1'b0;
            if (held == 3) pipe_stall_in = 1'b0;
         end
         @(posedge clk); #1;
         guard++;
      end
      pipe_stall_in = 1'b0;
      check1("hold_func_held", ok, 1'b1);
      check32("hold_cycles", 32'(held), 32'd3);
      check32("hold_retire_func", 32'(u_func), 32'(FUNC_NOP));
      check1("hold_retire_ready", in_ready, 1'b0);
      check1("hold_retire_stall", stall_req, 1'b0);
      check1("hold_retire_u_reg_stall", u_reg_stall, 1'b0);
      @(posedge clk); #1;
      check1("hold_back_idle", in_ready, 1'b1);
      check32("hold_launches", 32'(launches - n0), 32'd1);
      m_hi = 32'd2; m_lo = 32'd8;
      run_op(OP_MFLO, 32'h0, 32'h0, d);
      check32("hold_lo", d, 32'd8);

      // Flush at BUSY cycle 10 of a divide: LO keeps the pre-divide value
      $display("seq: flush during divide");
      run_op(OP_MTLO, 32'h0000CAFE, 32'h0, d);
      issue(OP_DIV, 32'd1000, 32'd3);
      repeat (9) begin @(posedge clk); #1; end
      check1("flush_busy_before", stall_req, 1'b1);
      pipe_flush = 1'b1;
      @(posedge clk); #1;
      pipe_flush = 1'b0;
      check1("flush_pulse", u_flush, 1'b1);
      check32("flush_func_nop", 32'(u_func), 32'(FUNC_NOP));
      check1("flush_idle", in_ready, 1'b1);
      @(posedge clk); #1;
      check1("flush_pulse_end", u_flush, 1'b0);
      run_op(OP_MFLO, 32'h0, 32'h0, d);
      check32("flush_lo_kept", d, 32'h0000CAFE);

      // Flush and request in the same IDLE cycle: nothing accepted
      $display("seq: flush with request in idle");
      in_op = OP_MTHI; in_src_a = 32'hDEADBEEF; in_valid = 1'b1; pipe_flush = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; pipe_flush = 1'b0;
      check1("idle_flush_no_write", u_hi_write, 1'b0);
      check1("idle_flush_no_valid", out_valid, 1'b0);
      check1("idle_flush_no_uflush", u_flush, 1'b0);
      run_op(OP_MFHI, 32'h0, 32'h0, d);

      // Randomised ops against the reference HI/LO
      for (int i = 0; i < 40; i++) begin
         rop = 3'($urandom_range(0, 7));
         ra  = $urandom;
         rb  = $urandom;
         if (rop == OP_DIV || rop == OP_DIVU) begin
            if (rb == 32'h0) rb = 32'h1;
            if (rop == OP_DIV && ra == 32'h80000000 && rb == 32'hFFFFFFFF) rb = 32'h1;
         end
         run_op(rop, ra, rb, d);
      end
      run_op(OP_MFHI, 32'h0, 32'h0, d);
      run_op(OP_MFLO, 32'h0, 32'h0, d);

      // Hung unit: watchdog fires on the 64th BUSY cycle
      $display("seq: watchdog");
      hang = 1'b1;
      issue(OP_MULT, 32'd3, 32'd4);
      check1("wd_err_initial", err_timeout, 1'b0);
      cyc = 1;
      while (u_flush !== 1'b1 && cyc < 200) begin
         if (cyc == 64) check1("wd_err_at_64", err_timeout, 1'b0);
         @(posedge clk); #1;
         cyc++;
      end
      hang = 1'b0;
      check32("wd_busy_cycles", 32'(cyc - 1), 32'd64);
      check1("wd_err_set", err_timeout, 1'b1);
      check1("wd_idle", in_ready, 1'b1);
      check32("wd_func_nop", 32'(u_func), 32'(FUNC_NOP));
      @(posedge clk); #1;
      check1("wd_pulse_end", u_flush, 1'b0);
      check1("wd_err_sticky", err_timeout, 1'b1);

      // Reset in the middle of a divide
      $display("seq: reset mid-op");
      issue(OP_DIVU, 32'd9, 32'd2);
      repeat (5) begin @(posedge clk); #1; end
      rst = 1'b0;
      @(posedge clk); #1;
      check32("rstmid_func", 32'(u_func), 32'(FUNC_NOP));
      check1("rstmid_err", err_timeout, 1'b0);
      check1("rstmid_stall_req", stall_req, 1'b0);
      check32("rstmid_src_a", u_src_a, 32'h0);
      rst = 1'b1;
      m_hi = '0; m_lo = '0;
      @(posedge clk); #1;
      check1("rstmid_ready", in_ready, 1'b1);
      run_op(OP_MFLO, 32'h0, 32'h0, d);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
